ocram_rr_arbiter: RTL and testbench
===================================

// Module: ocram_rr_arbiter
// PURPOSE
//  Two-port round-robin arbiter that shares the single FPGA-side Avalon-MM master into the on-chip RAM
//  (ocram_master_0 path) between two fabric requesters (e.g. LED/export sequencer and HPS-mailbox logic).
//  One transaction in flight at a time; handles waitrequest back-pressure, readdatavalid return and read timeout.
//  Sits between the fabric requesters and the Qsys system's OCRAM master interface.
// PARAMETERS
//  ADDR_W      16   word address width of OCRAM master
//  DATA_W      8    data width (matches 8-bit OCRAM export path)
//  RD_TIMEOUT  64   cycles to wait for readdatavalid before aborting a read with error (>=2)
// PORTS
//  clk_clk            in   1       system clock
//  reset_reset        in   1       synchronous, active-high reset
//  rq0_valid          in   1       requester 0 command valid; held until rq0_ready
//  rq0_write          in   1       1=write, 0=read
//  rq0_addr           in   ADDR_W  word address
//  rq0_wdata          in   DATA_W  write data
//  rq0_ready          out  1       1-cycle pulse: command accepted by slave
//  rq0_rvalid         out  1       1-cycle pulse: read data / error returned
//  rq0_rdata          out  DATA_W  read data (0 on error)
//  rq0_rerr           out  1       qualifies rq0_rvalid: read timed out
//  rq1_*              same set as rq0_* for requester 1
//  avm_address        out  ADDR_W  to OCRAM master
//  avm_read           out  1
//  avm_write          out  1
//  avm_writedata      out  DATA_W
//  avm_waitrequest    in   1
//  avm_readdata       in   DATA_W
//  avm_readdatavalid  in   1
//  busy               out  1       FSM not in IDLE
//  grant_id           out  1       requester currently/last granted
// BEHAVIOUR
//  Reset: state=IDLE; avm_read/avm_write=0; avm_address/writedata=0; all ready/rvalid/rerr=0; rdata=0;
//   busy=0; grant_id=0; last-grant pointer=1 (so requester 0 wins the first tie).
//  FSM states IDLE, CMD, RDWAIT.
//  IDLE: if exactly one valid, grant it; if both, grant the one != last-grant pointer. On grant latch
//   write/addr/wdata of winner, set grant_id, update pointer, go CMD next edge. No valid -> stay.
//  CMD: avm_read=~wr_l or avm_write=wr_l, driven from latched fields (registered, stable while waitrequest=1).
//   Accept cycle = CMD && !avm_waitrequest: rqN_ready=1 for granted N (combinational, that cycle only);
//   strobes deassert next edge. Write -> IDLE; read -> RDWAIT with timeout counter cleared.
//  RDWAIT: avm_readdatavalid=1 -> register rdata to granted port, rvalid pulses next cycle, rerr=0, -> IDLE.
//   Counter reaches RD_TIMEOUT-1 without readdatavalid -> rvalid=1, rerr=1, rdata=0 next cycle, -> IDLE.
//   Readdatavalid and timeout on same cycle: data wins (rerr=0).
//  Min latency: valid in IDLE @T0 -> avm strobe @T1 -> ready @T1 (no wait) -> read data @>=T2, rvalid 1 cycle later.
//  Back-to-back: requester re-asserting valid after ready is re-arbitrated in IDLE; with both valid continuously
//   grants strictly alternate 0,1,0,1.
//  Requester dropping valid before ready is illegal; latched command still completes, ready/rvalid still pulse.
//  avm_readdatavalid outside RDWAIT is ignored (stale return after timeout or reset).
//  Reset mid-operation: next edge returns to reset state; in-flight transaction abandoned, no ready/rvalid issued.
//  Non-granted port's ready/rvalid/rerr remain 0 at all times.
// TESTING
//  T1 rq0 write addr 0x0010 data 0xA5, waitrequest=0 -> avm_write 1 cycle @T1 with 0x0010/0xA5, rq0_ready @T1.
//  T2 rq1 read 0x0020, waitrequest high 3 cycles, readdata 0x3C 2 cycles after accept -> strobe held 4 cycles,
//     rq1_ready on 4th, rq1_rvalid=1 rdata=0x3C rerr=0 one cycle after readdatavalid.
//  T3 both valid continuously, 6 writes each -> grants 0,1,0,1,...; no port ever waits >1 transaction.
//  T4 rq0 read, readdatavalid never asserted -> rq0_rvalid=1, rerr=1, rdata=0 after RD_TIMEOUT cycles; late
//     readdatavalid afterwards ignored; next transaction completes normally.
//  T5 reset_reset asserted during CMD with waitrequest=1 -> next edge strobes=0, busy=0, no ready pulse;
//     first tie after reset granted to rq0.

Source files
------------

// File: rtl/ocram_rr_arbiter.sv
// Two-port round-robin arbiter sharing one Avalon-MM master into the on-chip RAM.
// One transaction in flight; handles waitrequest, readdatavalid return and read timeout.
module ocram_rr_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              rq0_valid,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_ready,
  output logic              rq0_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_rerr,
  input  logic              rq1_valid,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_ready,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_rerr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(RD_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RDWAIT} state_t;

  // Handshake: a requester holds valid with stable fields until its ready pulse;
  // ready is high only in the cycle the slave takes the strobe (CMD && !waitrequest).
  state_t                 r_state;
  logic                   r_wr;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_avm_read;
  logic                   r_avm_write;
  logic                   r_grant;
  logic                   r_last;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_rvalid;
  logic [1:0]             r_rerr;
  logic [1:0][DATA_W-1:0] r_rdata;

  logic w_any;
  logic w_win;
  logic w_accept;

  assign w_any    = rq0_valid | rq1_valid;
  // On a tie the pointer holds the last winner, so the other port goes next.
  assign w_win    = (rq0_valid && rq1_valid) ? ~r_last : rq1_valid;
  assign w_accept = (r_state == ST_CMD) && !avm_waitrequest;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_rvalid    <= '0;
      r_rerr      <= '0;
      r_rdata     <= '0;
    end else begin
      r_rvalid <= '0;
      r_rerr   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_wr        <= w_win ? rq1_write : rq0_write;
            r_addr      <= w_win ? rq1_addr  : rq0_addr;
            r_wdata     <= w_win ? rq1_wdata : rq0_wdata;
            r_avm_read  <= w_win ? ~rq1_write : ~rq0_write;
            r_avm_write <= w_win ? rq1_write  : rq0_write;
            r_grant     <= w_win;
            r_last      <= w_win;
            r_state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!avm_waitrequest) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_cnt       <= '0;
            r_state     <= r_wr ? ST_IDLE : ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          // Returned data beats a timeout that expires in the same cycle.
          if (avm_readdatavalid) begin
            r_rvalid[r_grant] <= 1'b1;
            r_rdata[r_grant]  <= avm_readdata;
            r_state           <= ST_IDLE;
          end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            r_rvalid[r_grant] <= 1'b1;
            r_rerr[r_grant]   <= 1'b1;
            r_rdata[r_grant]  <= '0;
            r_state           <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rq0_ready     = w_accept & ~r_grant;
  assign rq1_ready     = w_accept & r_grant;
  assign rq0_rvalid    = r_rvalid[0];
  assign rq1_rvalid    = r_rvalid[1];
  assign rq0_rerr      = r_rerr[0];
  assign rq1_rerr      = r_rerr[1];
  assign rq0_rdata     = r_rdata[0];
  assign rq1_rdata     = r_rdata[1];
  assign avm_address   = r_addr;
  assign avm_writedata = r_wdata;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign busy          = (r_state != ST_IDLE);
  assign grant_id      = r_grant;

endmodule

// File: tb/tb_ocram_rr_arbiter.sv
// Bench for ocram_rr_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model and a bench-side Avalon slave.
module tb_ocram_rr_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int EW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rq_v[2];
  logic          rq_w[2];
  logic [AW-1:0] rq_a[2];
  logic [DW-1:0] rq_d[2];
  logic          rq_rdy[2];
  logic          rq_rv[2];
  logic          rq_re[2];
  logic [DW-1:0] rq_rd[2];

  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic          waitreq, rdv;
  logic [DW-1:0] avm_readdata;
  logic          busy, grant_id;

  ocram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .rq0_valid(rq_v[0]), .rq0_write(rq_w[0]), .rq0_addr(rq_a[0]), .rq0_wdata(rq_d[0]),
    .rq0_ready(rq_rdy[0]), .rq0_rvalid(rq_rv[0]), .rq0_rdata(rq_rd[0]), .rq0_rerr(rq_re[0]),
    .rq1_valid(rq_v[1]), .rq1_write(rq_w[1]), .rq1_addr(rq_a[1]), .rq1_wdata(rq_d[1]),
    .rq1_ready(rq_rdy[1]), .rq1_rvalid(rq_rv[1]), .rq1_rdata(rq_rd[1]), .rq1_rerr(rq_re[1]),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(waitreq), .avm_readdata(avm_readdata),
    .avm_readdatavalid(rdv), .busy(busy), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bench-side Avalon slave ----------------
  bit            s_mode = 1'b0;
  logic          d_wreq, d_rdv;
  logic [DW-1:0] d_rdata;
  logic [DW-1:0] mem[16];
  bit            s_pend = 1'b0;
  int            s_cyc  = 0;
  int            s_due;
  logic [DW-1:0] s_data;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 3);
    waitreq = 1'b0; rdv = 1'b0; avm_readdata = '0;
    forever begin
      @(posedge clk);
      s_cyc++;
      #2;
      if (s_mode) begin
        waitreq = ($urandom_range(0, 2) == 0);
        if (s_pend && s_cyc == s_due) begin
          rdv = 1'b1; avm_readdata = s_data; s_pend = 1'b0;
        end else begin
          rdv = 1'b0; avm_readdata = 8'($urandom);
        end
      end else begin
        waitreq = d_wreq; rdv = d_rdv; avm_readdata = d_rdata;
      end
      @(negedge clk);
      if (s_mode && !rst) begin
        if (avm_read && !waitreq) begin
          int r;
          r = $urandom_range(0, 9);
          // Mostly prompt returns, plus returns landing exactly on, before and after the timeout.
          s_due  = s_cyc + ((r < 7) ? $urandom_range(1, 4) : (r == 7) ? TO : (r == 8) ? TO + 1 : TO - 1);
          s_pend = 1'b1;
          s_data = mem[avm_address[3:0]];
        end
        if (avm_write && !waitreq) mem[avm_address[3:0]] = avm_writedata;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  bit            m_act, m_acc, m_wr;
  int            m_port, m_last, m_gid, m_acc_cyc;
  int            m_cyc = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [EW-1:0] exp_q[$];   // {port, err, data} of the return due next cycle
  int            gnt_q[$];

  always @(negedge clk) begin
    logic [EW-1:0] e;
    bit has, e_cmd, e_rv;
    int win;
    has   = (exp_q.size() > 0);
    e     = has ? exp_q[0] : '0;
    e_cmd = m_act && !m_acc;
    if (chk_en) begin
      chk_b("avm_read", avm_read, e_cmd && !m_wr);
      chk_b("avm_write", avm_write, e_cmd && m_wr);
      chk_v("avm_address", avm_address, m_addr);
      chk_v("avm_writedata", 16'(avm_writedata), 16'(m_wdata));
      chk_b("busy", busy, m_act);
      chk_b("grant_id", grant_id, m_gid[0]);
      for (int p = 0; p < 2; p++) begin
        e_rv = has && (int'(e[EW-1]) == p);
        chk_b($sformatf("rq%0d_ready", p), rq_rdy[p], e_cmd && !waitreq && (m_port == p));
        chk_b($sformatf("rq%0d_rvalid", p), rq_rv[p], e_rv);
        chk_b($sformatf("rq%0d_rerr", p), rq_re[p], e_rv && e[DW]);
        if (e_rv) chk_v($sformatf("rq%0d_rdata", p), 16'(rq_rd[p]), 16'(e[DW-1:0]));
      end
    end
    if (has) void'(exp_q.pop_front());
    if (rq_rdy[0] === 1'b1) gnt_q.push_back(0);
    if (rq_rdy[1] === 1'b1) gnt_q.push_back(1);
    if (rst) begin
      m_act = 0; m_acc = 0; m_wr = 0; m_port = 0;
      m_addr = '0; m_wdata = '0; m_last = 1; m_gid = 0;
    end else if (!m_act) begin
      if (rq_v[0] || rq_v[1]) begin
        win     = (rq_v[0] && rq_v[1]) ? 1 - m_last : (rq_v[0] ? 0 : 1);
        m_act   = 1; m_acc = 0; m_port = win;
        m_wr    = rq_w[win]; m_addr = rq_a[win]; m_wdata = rq_d[win];
        m_last  = win; m_gid = win;
      end
    end else if (!m_acc) begin
      if (!waitreq) begin
        if (m_wr) m_act = 0;
        else begin m_acc = 1; m_acc_cyc = m_cyc; end
      end
    end else if (rdv) begin
      exp_q.push_back({m_port[0], 1'b0, avm_readdata});
      m_act = 0;
    end else if (m_cyc - m_acc_cyc == TO) begin
      exp_q.push_back({m_port[0], 1'b1, 8'h00});
      m_act = 0;
    end
    m_cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_req(input int p, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    int n;
    @(posedge clk); #1;
    rq_v[p] = 1'b1; rq_w[p] = wr; rq_a[p] = ad; rq_d[p] = dt;
    n = 0;
    do begin @(negedge clk); n++; end while (rq_rdy[p] !== 1'b1 && n < 500);
    n_checks++;
    if (rq_rdy[p] !== 1'b1) begin
      n_errors++;
      $display("FAIL rq%0d_accept_timeout: ready not seen, required within 500 cycles", p);
    end
  endtask

  task automatic rel_req(input int p);
    @(posedge clk); #1;
    rq_v[p] = 1'b0;
  endtask

  task automatic run_port(input int p, input int n, input bit mix);
    for (int i = 0; i < n; i++) begin
      logic wr;
      wr = mix ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(p, wr, 16'($urandom_range(0, 15)), 8'($urandom));
      if (mix && $urandom_range(0, 1) == 1) begin
        rel_req(p);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    rel_req(p);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, limit 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    d_wreq = 1'b0; d_rdv = 1'b0; d_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rq_v[p] = 1'b0; rq_w[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;
    smp();
    chk_b("rst_avm_read", avm_read, 1'b0);
    chk_b("rst_avm_write", avm_write, 1'b0);
    chk_v("rst_avm_address", avm_address, 16'h0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_grant_id", grant_id, 1'b0);
    chk_v("rst_rq0_rdata", 16'(rq_rd[0]), 16'h0);
    chk_v("rst_rq1_rdata", 16'(rq_rd[1]), 16'h0);

    // T1: single write, no back-pressure
    step(); rq_v[0] = 1'b1; rq_w[0] = 1'b1; rq_a[0] = 16'h0010; rq_d[0] = 8'hA5;
    smp(); chk_b("t1_idle_no_strobe", avm_write, 1'b0);
    step(); smp();
    chk_b("t1_avm_write", avm_write, 1'b1);
    chk_v("t1_addr", avm_address, 16'h0010);
    chk_v("t1_wdata", 16'(avm_writedata), 16'h00A5);
    chk_b("t1_rq0_ready", rq_rdy[0], 1'b1);
    chk_b("t1_rq1_ready", rq_rdy[1], 1'b0);
    step(); rq_v[0] = 1'b0;
    smp(); chk_b("t1_strobe_drop", avm_write, 1'b0); chk_b("t1_busy", busy, 1'b0);

    // T2: read with 3 cycles of waitrequest, data 2 cycles after accept
    step(); rq_v[1] = 1'b1; rq_w[1] = 1'b0; rq_a[1] = 16'h0020; d_wreq = 1'b1;
    smp(); chk_b("t2_idle", avm_read, 1'b0);
    step(); smp();
    chk_b("t2_read_c1", avm_read, 1'b1); chk_v("t2_addr", avm_address, 16'h0020);
    chk_b("t2_no_ready_c1", rq_rdy[1], 1'b0); chk_b("t2_grant_id", grant_id, 1'b1);
    step(); smp(); chk_b("t2_read_c2", avm_read, 1'b1); chk_b("t2_no_ready_c2", rq_rdy[1], 1'b0);
    step(); smp(); chk_b("t2_read_c3", avm_read, 1'b1); chk_b("t2_no_ready_c3", rq_rdy[1], 1'b0);
    step(); d_wreq = 1'b0;
    smp(); chk_b("t2_read_c4", avm_read, 1'b1); chk_b("t2_ready_c4", rq_rdy[1], 1'b1);
    chk_b("t2_rq0_ready", rq_rdy[0], 1'b0);
    step(); rq_v[1] = 1'b0;
    smp(); chk_b("t2_read_drop", avm_read, 1'b0);
    step(); d_rdv = 1'b1; d_rdata = 8'h3C;
    smp(); chk_b("t2_no_early_rvalid", rq_rv[1], 1'b0);
    step(); d_rdv = 1'b0;
    smp();
    chk_b("t2_rvalid", rq_rv[1], 1'b1); chk_v("t2_rdata", 16'(rq_rd[1]), 16'h003C);
    chk_b("t2_rerr", rq_re[1], 1'b0); chk_b("t2_rq0_rvalid", rq_rv[0], 1'b0);

    // T4: read timeout, stale return ignored, then a normal read
    step(); rq_v[0] = 1'b1; rq_w[0] = 1'b0; rq_a[0] = 16'h0030;
    step(); smp(); chk_b("t4_ready", rq_rdy[0], 1'b1); chk_b("t4_read", avm_read, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      step(); if (k == 1) rq_v[0] = 1'b0;
      smp(); chk_b("t4_no_early_rvalid", rq_rv[0], 1'b0);
    end
    step(); smp();
    chk_b("t4_rvalid", rq_rv[0], 1'b1); chk_b("t4_rerr", rq_re[0], 1'b1);
    chk_v("t4_rdata_zero", 16'(rq_rd[0]), 16'h0);
    step(); d_rdv = 1'b1; d_rdata = 8'hFF;
    smp(); chk_b("t4_idle", busy, 1'b0);
    step(); d_rdv = 1'b0;
    smp(); chk_b("t4_stale_rq0", rq_rv[0], 1'b0); chk_b("t4_stale_rq1", rq_rv[1], 1'b0);
    step(); rq_v[1] = 1'b1; rq_w[1] = 1'b0; rq_a[1] = 16'h0040;
    step(); smp(); chk_b("t4_next_ready", rq_rdy[1], 1'b1);
    step(); rq_v[1] = 1'b0; d_rdv = 1'b1; d_rdata = 8'h5A;
    step(); d_rdv = 1'b0;
    smp(); chk_b("t4_next_rvalid", rq_rv[1], 1'b1); chk_v("t4_next_rdata", 16'(rq_rd[1]), 16'h005A);
    chk_b("t4_next_rerr", rq_re[1], 1'b0);

    // T5: reset during a stalled command
    step(); rq_v[0] = 1'b1; rq_w[0] = 1'b1; rq_a[0] = 16'h0050; rq_d[0] = 8'h11; d_wreq = 1'b1;
    step(); smp(); chk_b("t5_write", avm_write, 1'b1); chk_b("t5_busy", busy, 1'b1);
    step(); rst = 1'b1; rq_v[0] = 1'b0;
    smp(); chk_b("t5_no_ready", rq_rdy[0], 1'b0);
    step(); rst = 1'b0;
    smp();
    chk_b("t5_strobe_off", avm_write, 1'b0); chk_b("t5_busy_off", busy, 1'b0);
    chk_b("t5_no_ready_after", rq_rdy[0], 1'b0);

    // T3: both requesters continuously valid; first tie after reset goes to rq0
    s_mode = 1'b1; d_wreq = 1'b0;
    gnt_q.delete();
    fork
      run_port(0, 6, 1'b0);
      run_port(1, 6, 1'b0);
    join
    chk_v("t3_grant_count", 16'(gnt_q.size()), 16'd12);
    for (int i = 0; i < 12 && i < gnt_q.size(); i++)
      chk_v($sformatf("t3_grant_%0d", i), 16'(gnt_q[i]), 16'(i % 2));

    // Randomized mixed traffic with random back-pressure, latencies and timeouts
    fork
      run_port(0, 40, 1'b1);
      run_port(1, 40, 1'b1);
    join
    repeat (3 * TO + 10) @(posedge clk);
    chk_v("final_idle_busy", 16'(busy), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
